// File: rtl/mem_write_ctrl_if.sv
// Bundles the write-arbiter handshake and the memory controller app/wdf bus.
// The master modport is the write controller's view; slave is the surrounding system.
interface mem_write_ctrl_if #(
    parameter int ADDR_WIDTH    = 30,
    parameter int MEM_DATA_BITS = 256
);
    logic                       wr_ddr_req;
    logic [7:0]                 wr_ddr_len;
    logic [ADDR_WIDTH-1:0]      wr_ddr_addr;
    logic                       wr_ddr_data_req;
    logic [MEM_DATA_BITS-1:0]   wr_ddr_data;
    logic                       wr_ddr_finish;
    logic                       app_en;
    logic [2:0]                 app_cmd;
    logic [ADDR_WIDTH-1:0]      app_addr;
    logic                       app_rdy;
    logic                       app_wdf_wren;
    logic                       app_wdf_end;
    logic [MEM_DATA_BITS-1:0]   app_wdf_data;
    logic [MEM_DATA_BITS/8-1:0] app_wdf_mask;
    logic                       app_wdf_rdy;

    modport master (
        input  wr_ddr_req, wr_ddr_len, wr_ddr_addr, wr_ddr_data, app_rdy, app_wdf_rdy,
        output wr_ddr_data_req, wr_ddr_finish, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

    modport slave (
        output wr_ddr_req, wr_ddr_len, wr_ddr_addr, wr_ddr_data, app_rdy, app_wdf_rdy,
        input  wr_ddr_data_req, wr_ddr_finish, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/mem_write_ctrl.sv
// Burst write controller: issues app write commands and streams data through a 4-deep FIFO.
// Define WR_TIMEOUT_EN to build in the no-progress watchdog (wr_timeout_o otherwise tied 0).
module mem_write_ctrl #(
    parameter real TCQ            = 0.1,
    parameter int  MEM_DATA_BITS  = 256,
    parameter int  ADDR_WIDTH     = 30,
    parameter int  ADDR_STEP      = 8,
    parameter int  TIMEOUT_CYCLES = 8000
) (
    input  logic             ddr_clk_i,
    input  logic             ddr_rst_i,
    mem_write_ctrl_if.master bus,
    output logic             wr_timeout_o
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    if (TCQ < 0.0 || TIMEOUT_CYCLES < 1 || ADDR_STEP < 0) begin : gBadParams
        $error("mem_write_ctrl: invalid parameter values");
    end

    state_e                   state_q;
    logic [8:0]               len_q, cmdCnt_q, pullCnt_q, popCnt_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic                     appEn_q, dataReq_q, inflight_q, finish_q;
    logic [MEM_DATA_BITS-1:0] fifo_q [4];
    logic [1:0]               wrPtr_q, rdPtr_q;
    logic [2:0]               count_q;

    logic       accept, pop, timeoutHit, room;
    logic [2:0] count_d;
    logic [8:0] pullCnt_d;

    always_comb begin
        accept    = appEn_q && bus.app_rdy;
        pop       = (count_q != 3'd0) && bus.app_wdf_rdy;
        count_d   = count_q + {2'b00, inflight_q} - {2'b00, pop};
        pullCnt_d = pullCnt_q + {8'd0, dataReq_q};
        // Next cycle's pull must fit behind the stored words plus the one still arriving
        room      = (count_d + {2'b00, dataReq_q}) < 3'd4;
    end

`ifdef WR_TIMEOUT_EN
    localparam logic [31:0] TimeoutLimit = TIMEOUT_CYCLES;
    logic [31:0] wdCnt_q;
    logic        wrTimeout_q;

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i || state_q != XFER || accept || pop) begin
            wdCnt_q <= '0;
        end else begin
            wdCnt_q <= wdCnt_q + 32'd1;
        end
        if (ddr_rst_i) begin
            wrTimeout_q <= 1'b0;
        end else if (state_q == XFER && timeoutHit) begin
            wrTimeout_q <= 1'b1;
        end
    end

    assign timeoutHit   = wdCnt_q > TimeoutLimit;
    assign wr_timeout_o = wrTimeout_q;
`else
    assign timeoutHit   = 1'b0;
    assign wr_timeout_o = 1'b0;
`endif

    // FIFO storage carries no reset; occupancy and pointers decide what is valid
    always_ff @(posedge ddr_clk_i) begin
        if (inflight_q) begin
            fifo_q[wrPtr_q] <= bus.wr_ddr_data;
        end
    end

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cmdCnt_q   <= '0;
            pullCnt_q  <= '0;
            popCnt_q   <= '0;
            addr_q     <= '0;
            appEn_q    <= 1'b0;
            dataReq_q  <= 1'b0;
            inflight_q <= 1'b0;
            finish_q   <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            finish_q   <= 1'b0;
            inflight_q <= dataReq_q;
            case (state_q)
                IDLE: begin
                    appEn_q   <= 1'b0;
                    dataReq_q <= 1'b0;
                    if (bus.wr_ddr_req) begin
                        if (bus.wr_ddr_len != 8'd0) begin
                            len_q     <= {1'b0, bus.wr_ddr_len};
                            addr_q    <= bus.wr_ddr_addr;
                            cmdCnt_q  <= '0;
                            pullCnt_q <= '0;
                            popCnt_q  <= '0;
                            appEn_q   <= 1'b1;
                            dataReq_q <= 1'b1;
                            state_q   <= XFER;
                        end else begin
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                XFER: begin
                    if (timeoutHit) begin
                        appEn_q    <= 1'b0;
                        dataReq_q  <= 1'b0;
                        inflight_q <= 1'b0;
                        wrPtr_q    <= '0;
                        rdPtr_q    <= '0;
                        count_q    <= '0;
                        finish_q   <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        if (accept) begin
                            cmdCnt_q <= cmdCnt_q + 9'd1;
                            addr_q   <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                            if (cmdCnt_q + 9'd1 == len_q) begin
                                appEn_q <= 1'b0;
                            end
                        end
                        if (inflight_q) begin
                            wrPtr_q <= wrPtr_q + 2'd1;
                        end
                        if (pop) begin
                            rdPtr_q  <= rdPtr_q + 2'd1;
                            popCnt_q <= popCnt_q + 9'd1;
                        end
                        count_q   <= count_d;
                        pullCnt_q <= pullCnt_d;
                        dataReq_q <= (pullCnt_d < len_q) && room;
                        if (cmdCnt_q == len_q && popCnt_q == len_q) begin
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ddr_data_req = dataReq_q;
    assign bus.wr_ddr_finish   = finish_q;
    assign bus.app_en          = appEn_q;
    assign bus.app_cmd         = 3'b000;
    assign bus.app_addr        = addr_q;
    assign bus.app_wdf_wren    = count_q != 3'd0;
    assign bus.app_wdf_end     = count_q != 3'd0;
    assign bus.app_wdf_data    = (count_q != 3'd0) ? fifo_q[rdPtr_q] : '0;
    assign bus.app_wdf_mask    = '0;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl: models the write arbiter's one-cycle data return
// and records app/wdf traffic, which each scenario task then checks against hand values.
module tb_mem_write_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic timeout;

    always #5 clk = ~clk;

    mem_write_ctrl_if #(.ADDR_WIDTH(30), .MEM_DATA_BITS(256)) bus ();

    mem_write_ctrl #(
        .TCQ(0.1), .MEM_DATA_BITS(256), .ADDR_WIDTH(30), .ADDR_STEP(8), .TIMEOUT_CYCLES(8000)
    ) dut (
        .ddr_clk_i(clk),
        .ddr_rst_i(rst),
        .bus(bus),
        .wr_timeout_o(timeout)
    );

    int compared = 0;
    int mismatched = 0;

    // Traffic recorded by the per-cycle monitor
    logic [29:0]  acceptedAddr[$];
    logic [255:0] poppedData[$];
    int finishCount, stallViol, endViol, maxOut, pullsSeen, pullIdx;
    int cycleNo, lastAcceptCycle, finishCycle, wdfStallLeft, rdyMode;
    bit pullPrev, stalledPrev;
    logic [29:0] stalledAddr;

    function automatic logic [255:0] beatData(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {8{w}};
    endfunction

    // One clock: supply data for last cycle's pull, drive ready inputs, record traffic
    task automatic cycle();
        int outstanding;
        @(posedge clk);
        #1;
        cycleNo++;
        if (pullPrev) begin
            bus.wr_ddr_data = beatData(pullIdx);
            pullIdx++;
        end else begin
            bus.wr_ddr_data = '0;
        end
        pullPrev = bus.wr_ddr_data_req;
        if (pullPrev) pullsSeen++;
        case (rdyMode)
            0: bus.app_rdy = 1'b1;
            1: bus.app_rdy = 1'b0;
            default: bus.app_rdy = ~bus.app_rdy;
        endcase
        bus.app_wdf_rdy = (wdfStallLeft > 0) ? 1'b0 : 1'b1;
        if (wdfStallLeft > 0) wdfStallLeft--;
        #1;
        if (stalledPrev && (bus.app_en !== 1'b1 || bus.app_addr !== stalledAddr)) stallViol++;
        stalledPrev = bus.app_en && !bus.app_rdy;
        stalledAddr = bus.app_addr;
        outstanding = pullsSeen - poppedData.size();
        if (outstanding > maxOut) maxOut = outstanding;
        if (bus.app_en && bus.app_rdy) begin
            acceptedAddr.push_back(bus.app_addr);
            lastAcceptCycle = cycleNo;
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) poppedData.push_back(bus.app_wdf_data);
        if (bus.app_wdf_end !== bus.app_wdf_wren) endViol++;
        if (bus.wr_ddr_finish === 1'b1) begin
            finishCount++;
            finishCycle = cycleNo;
        end
    endtask

    task automatic applyStimulus(input int len, input logic [29:0] addr);
        acceptedAddr.delete();
        poppedData.delete();
        finishCount = 0; stallViol = 0; endViol = 0; maxOut = 0;
        pullsSeen = 0; pullIdx = 0; pullPrev = 0; stalledPrev = 0;
        cycleNo = 0; lastAcceptCycle = 0; finishCycle = 0;
        bus.wr_ddr_req  = 1'b1;
        bus.wr_ddr_len  = 8'(len);
        bus.wr_ddr_addr = addr;
        cycle();
        bus.wr_ddr_req  = 1'b0;
        bus.wr_ddr_len  = 8'd0;
        bus.wr_ddr_addr = '0;
    endtask

    task automatic runUntilFinish(input int budget, output bit expired);
        int n = 0;
        while (finishCount == 0 && n < budget) begin
            cycle();
            n++;
        end
        expired = (finishCount == 0);
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        compared++; if ({bus.wr_ddr_data_req, bus.wr_ddr_finish, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end} !== 5'b0) begin
            mismatched++; $display("[TB] FAIL reset_ctrl: got %b, want 00000", {bus.wr_ddr_data_req, bus.wr_ddr_finish, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}); end
        compared++; if (bus.app_addr !== 30'd0) begin
            mismatched++; $display("[TB] FAIL reset_addr: got %h, want 0", bus.app_addr); end
        compared++; if (bus.app_cmd !== 3'b000 || bus.app_wdf_mask !== 32'd0) begin
            mismatched++; $display("[TB] FAIL reset_cmd_mask: got %b/%h, want 000/0", bus.app_cmd, bus.app_wdf_mask); end
        compared++; if (bus.app_wdf_data !== 256'd0) begin
            mismatched++; $display("[TB] FAIL reset_wdf_data: got %h, want 0", bus.app_wdf_data); end
        compared++; if (timeout !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_timeout: got %b, want 0", timeout); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        bit expired;
        rdyMode = 0; wdfStallLeft = 0;
        applyStimulus(4, 30'h100);
        runUntilFinish(50, expired);
        compared++; if (expired) begin mismatched++; $display("[TB] FAIL basic_finish: got none, want pulse"); end
        compared++; if (acceptedAddr.size() !== 4) begin
            mismatched++; $display("[TB] FAIL basic_cmd_count: got %0d, want 4", acceptedAddr.size()); end
        for (int i = 0; i < 4 && i < acceptedAddr.size(); i++) begin
            compared++; if (acceptedAddr[i] !== 30'(32'h100 + 8 * i)) begin
                mismatched++; $display("[TB] FAIL basic_addr%0d: got %h, want %h", i, acceptedAddr[i], 30'(32'h100 + 8 * i)); end
        end
        compared++; if (poppedData.size() !== 4) begin
            mismatched++; $display("[TB] FAIL basic_beats: got %0d, want 4", poppedData.size()); end
        for (int i = 0; i < 4 && i < poppedData.size(); i++) begin
            compared++; if (poppedData[i] !== beatData(i)) begin
                mismatched++; $display("[TB] FAIL basic_data%0d: got %h, want %h", i, poppedData[i], beatData(i)); end
        end
        compared++; if (finishCount !== 1) begin
            mismatched++; $display("[TB] FAIL basic_finish_count: got %0d, want 1", finishCount); end
        compared++; if (endViol !== 0) begin
            mismatched++; $display("[TB] FAIL basic_wdf_end: got %0d bad cycles, want 0", endViol); end
        compared++; if ({bus.app_en, bus.wr_ddr_data_req, bus.app_wdf_wren} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL basic_idle_after: got %b, want 000", {bus.app_en, bus.wr_ddr_data_req, bus.app_wdf_wren}); end
    endtask

    task automatic test_zero_len();
        bus.wr_ddr_req = 1'b1; bus.wr_ddr_len = 8'd0; bus.wr_ddr_addr = 30'h77;
        acceptedAddr.delete();
        cycle();
        bus.wr_ddr_req = 1'b0;
        compared++; if ({bus.wr_ddr_finish, bus.app_en, bus.wr_ddr_data_req} !== 3'b100) begin
            mismatched++; $display("[TB] FAIL zero_len_done: got %b, want 100", {bus.wr_ddr_finish, bus.app_en, bus.wr_ddr_data_req}); end
        cycle();
        compared++; if (bus.wr_ddr_finish !== 1'b0) begin
            mismatched++; $display("[TB] FAIL zero_len_pulse_width: got %b, want 0", bus.wr_ddr_finish); end
        repeat (2) cycle();
        compared++; if (acceptedAddr.size() !== 0) begin
            mismatched++; $display("[TB] FAIL zero_len_traffic: got %0d cmds, want 0", acceptedAddr.size()); end
    endtask

    task automatic test_backpressure();
        bit expired;
        rdyMode = 0; wdfStallLeft = 20;
        applyStimulus(8, 30'h4000);
        runUntilFinish(100, expired);
        compared++; if (expired) begin mismatched++; $display("[TB] FAIL bp_finish: got none, want pulse"); end
        compared++; if (maxOut > 4) begin
            mismatched++; $display("[TB] FAIL bp_outstanding: got %0d, want at most 4", maxOut); end
        compared++; if (pullsSeen !== 8) begin
            mismatched++; $display("[TB] FAIL bp_pulls: got %0d, want 8", pullsSeen); end
        compared++; if (poppedData.size() !== 8) begin
            mismatched++; $display("[TB] FAIL bp_beats: got %0d, want 8", poppedData.size()); end
        for (int i = 0; i < 8 && i < poppedData.size(); i++) begin
            compared++; if (poppedData[i] !== beatData(i)) begin
                mismatched++; $display("[TB] FAIL bp_data%0d: got %h, want %h", i, poppedData[i], beatData(i)); end
        end
        compared++; if (finishCount !== 1) begin
            mismatched++; $display("[TB] FAIL bp_finish_count: got %0d, want 1", finishCount); end
    endtask

    task automatic test_cmd_stall();
        bit expired;
        rdyMode = 2; wdfStallLeft = 0; bus.app_rdy = 1'b0;
        applyStimulus(3, 30'h800);
        runUntilFinish(60, expired);
        compared++; if (expired) begin mismatched++; $display("[TB] FAIL stall_finish: got none, want pulse"); end
        compared++; if (stallViol !== 0) begin
            mismatched++; $display("[TB] FAIL stall_hold: got %0d unstable cycles, want 0", stallViol); end
        compared++; if (acceptedAddr.size() !== 3) begin
            mismatched++; $display("[TB] FAIL stall_cmd_count: got %0d, want 3", acceptedAddr.size()); end
        compared++; if (acceptedAddr.size() == 3 && acceptedAddr[2] !== 30'h810) begin
            mismatched++; $display("[TB] FAIL stall_last_addr: got %h, want 810", acceptedAddr[2]); end
        compared++; if (finishCycle <= lastAcceptCycle) begin
            mismatched++; $display("[TB] FAIL stall_finish_order: got cycle %0d, want after %0d", finishCycle, lastAcceptCycle); end
        rdyMode = 0;
    endtask

    task automatic test_addr_wrap();
        bit expired;
        rdyMode = 0; wdfStallLeft = 0;
        applyStimulus(2, 30'h3FFF_FFF8);
        runUntilFinish(40, expired);
        compared++; if (acceptedAddr.size() !== 2) begin
            mismatched++; $display("[TB] FAIL wrap_cmd_count: got %0d, want 2", acceptedAddr.size()); end
        compared++; if (acceptedAddr.size() == 2 && acceptedAddr[1] !== 30'd0) begin
            mismatched++; $display("[TB] FAIL wrap_addr: got %h, want 0", acceptedAddr[1]); end
        compared++; if (expired || finishCount !== 1) begin
            mismatched++; $display("[TB] FAIL wrap_finish: got %0d, want 1", finishCount); end
    endtask

    task automatic test_reset_mid_burst();
        bit expired;
        int n = 0;
        rdyMode = 0; wdfStallLeft = 0;
        applyStimulus(6, 30'h2000);
        while (poppedData.size() < 2 && n < 20) begin cycle(); n++; end
        compared++; if (poppedData.size() < 2) begin
            mismatched++; $display("[TB] FAIL midrst_progress: got %0d beats, want 2", poppedData.size()); end
        rst = 1'b1;
        cycle();
        compared++; if ({bus.wr_ddr_data_req, bus.wr_ddr_finish, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end} !== 5'b0 || bus.app_addr !== 30'd0) begin
            mismatched++; $display("[TB] FAIL midrst_outputs: got %b/%h, want 00000/0", {bus.wr_ddr_data_req, bus.wr_ddr_finish, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}, bus.app_addr); end
        compared++; if (bus.app_wdf_data !== 256'd0) begin
            mismatched++; $display("[TB] FAIL midrst_wdf_data: got %h, want 0", bus.app_wdf_data); end
        rst = 1'b0;
        repeat (5) cycle();
        compared++; if (finishCount !== 0) begin
            mismatched++; $display("[TB] FAIL midrst_no_finish: got %0d, want 0", finishCount); end
        applyStimulus(1, 30'h40);
        runUntilFinish(30, expired);
        compared++; if (expired || finishCount !== 1) begin
            mismatched++; $display("[TB] FAIL midrst_fresh_finish: got %0d, want 1", finishCount); end
        compared++; if (acceptedAddr.size() !== 1 || acceptedAddr[0] !== 30'h40) begin
            mismatched++; $display("[TB] FAIL midrst_fresh_addr: got %0d cmds, want 1 at 40", acceptedAddr.size()); end
        compared++; if (poppedData.size() !== 1 || poppedData[0] !== beatData(0)) begin
            mismatched++; $display("[TB] FAIL midrst_fresh_data: got %0d beats, want 1 of %h", poppedData.size(), beatData(0)); end
    endtask

`ifdef WR_TIMEOUT_EN
    task automatic test_watchdog();
        bit expired;
        rdyMode = 1; wdfStallLeft = 0;
        applyStimulus(2, 30'h500);
        runUntilFinish(8200, expired);
        compared++; if (expired || finishCount !== 1) begin
            mismatched++; $display("[TB] FAIL wd_finish: got %0d, want 1", finishCount); end
        compared++; if (timeout !== 1'b1) begin
            mismatched++; $display("[TB] FAIL wd_flag: got %b, want 1", timeout); end
        compared++; if (finishCycle <= 8000) begin
            mismatched++; $display("[TB] FAIL wd_latency: got cycle %0d, want above 8000", finishCycle); end
        compared++; if ({bus.app_en, bus.app_wdf_wren} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL wd_quiet: got %b, want 00", {bus.app_en, bus.app_wdf_wren}); end
        rdyMode = 0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.wr_ddr_req = 1'b0; bus.wr_ddr_len = 8'd0; bus.wr_ddr_addr = '0;
        bus.wr_ddr_data = '0; bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
        rdyMode = 0; wdfStallLeft = 0;
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_cmd_stall();
        test_addr_wrap();
        test_reset_mid_burst();
`ifdef WR_TIMEOUT_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
